// File: rtl/csa_resolver.sv
// Iterative carry-propagate resolver for a redundant (sum, carry) pair.
// Resolves CHUNK bits per cycle; optional OR-approximated LSB region.
module csa_resolver #(
    parameter int WIDTH      = 8,
    parameter int CHUNK      = 4,
    parameter int APPROX_LSB = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic [WIDTH-1:0]   carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   result,
    output logic               gate_en
);

    localparam int unsigned AW     = WIDTH + 1;
    localparam int unsigned RW     = WIDTH + 2;
    localparam int unsigned NCHUNK = (WIDTH + CHUNK) / CHUNK;
    localparam int unsigned PADW   = NCHUNK * CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned BW     = $clog2(PADW + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [AW-1:0]     r_a;
    logic [AW-1:0]     r_b;
    logic [RW-1:0]     r_res;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [BW-1:0]     r_base;

    logic [AW-1:0]     w_a_full;
    logic [AW-1:0]     w_b_full;
    logic [AW-1:0]     w_a_cap;
    logic [AW-1:0]     w_b_cap;
    logic [CHUNK-1:0]  w_a_chk;
    logic [CHUNK-1:0]  w_b_chk;
    logic [CHUNK:0]    w_chunk;
    logic [RW-1:0]     w_res_next;
    logic              w_last;

    // Approximate region folded in at capture: A keeps A|B, B is zeroed, so the
    // exact adder yields the OR with no carry leaving the region.
    always_comb begin
        w_a_full = {1'b0, sum_in};
        w_b_full = {carry_in, 1'b0};
        w_a_cap  = '0;
        w_b_cap  = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (i < APPROX_LSB) begin
                w_a_cap[i] = w_a_full[i] | w_b_full[i];
                w_b_cap[i] = 1'b0;
            end else begin
                w_a_cap[i] = w_a_full[i];
                w_b_cap[i] = w_b_full[i];
            end
        end
    end

    // Chunk operands beyond the stored width read as the zero padding.
    always_comb begin
        w_a_chk = '0;
        w_b_chk = '0;
        for (int unsigned j = 0; j < AW; j++) begin
            for (int unsigned k = 0; k < CHUNK; k++) begin
                if (j == 32'(r_base) + k) begin
                    w_a_chk[k] = r_a[j];
                    w_b_chk[k] = r_b[j];
                end
            end
        end
    end

    assign w_chunk = {1'b0, w_a_chk} + {1'b0, w_b_chk} + (CHUNK+1)'(r_carry);
    assign w_last  = (r_idx == IDXW'(NCHUNK - 1));

    // Final carry lands in the result only when it falls inside the result width.
    always_comb begin
        w_res_next = r_res;
        for (int unsigned j = 0; j < RW; j++) begin
            for (int unsigned k = 0; k < CHUNK; k++) begin
                if (j == 32'(r_base) + k) begin
                    w_res_next[j] = w_chunk[k];
                end
            end
            if (w_last && (j == 32'(r_base) + CHUNK)) begin
                w_res_next[j] = w_chunk[CHUNK];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        gate_en   = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_base  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_a_cap;
                        r_b     <= w_b_cap;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_base  <= '0;
                    end
                end
                BUSY: begin
                    r_res   <= w_res_next;
                    r_carry <= w_chunk[CHUNK];
                    r_idx   <= r_idx + IDXW'(1);
                    r_base  <= r_base + BW'(CHUNK);
                end
                default: ;
            endcase
        end
    end

    assign result = r_res;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: directed vectors on WIDTH=8/CHUNK=4,
// an approximate-mode instance, and random traffic across CHUNK 1..9.
module tb_csa_resolver;

    localparam int NR = 24;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;

    logic        in_valid, in_ready, out_valid, out_ready, gate_en;
    logic [7:0]  sum_in, carry_in;
    logic [9:0]  result;
    logic [9:0]  exp_q[$];
    logic [9:0]  mon_e;
    logic        rr_main;

    logic        a_vi, a_ri, a_vo, a_ro, a_ge;
    logic [7:0]  a_s, a_c;
    logic [9:0]  a_res;
    logic [9:0]  apx_q[$];
    logic [9:0]  apx_e;

    logic        go_rand;
    logic [9:1]  rand_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    csa_resolver #(.WIDTH(8), .CHUNK(4), .APPROX_LSB(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .gate_en(gate_en)
    );

    csa_resolver #(.WIDTH(8), .CHUNK(4), .APPROX_LSB(4)) u_apx (
        .clk(clk), .rst(rst), .in_valid(a_vi), .in_ready(a_ri),
        .sum_in(a_s), .carry_in(a_c), .out_valid(a_vo),
        .out_ready(a_ro), .result(a_res), .gate_en(a_ge)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL main_unexpected: result=0x%0h with no pending expectation", result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("main_result", result, mon_e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && a_vo && a_ro) begin
            if (apx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL apx_unexpected: result=0x%0h with no pending expectation", a_res);
            end else begin
                apx_e = apx_q.pop_front();
                chk("apx_result", a_res, apx_e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_main) out_ready = 1'($urandom_range(0, 1));
        end
    end

    for (genvar gc = 1; gc <= 9; gc++) begin : g_ck
        logic       vi, ri, vo, ro, ge;
        logic [7:0] s, c;
        logic [9:0] res;
        logic [9:0] q[$];
        logic [9:0] e;
        int         nrx;

        csa_resolver #(.WIDTH(8), .CHUNK(gc), .APPROX_LSB(0)) u_rnd (
            .clk(clk), .rst(rst), .in_valid(vi), .in_ready(ri),
            .sum_in(s), .carry_in(c), .out_valid(vo),
            .out_ready(ro), .result(res), .gate_en(ge)
        );

        initial begin
            int n;
            vi  = 1'b0;
            ro  = 1'b0;
            s   = '0;
            c   = '0;
            nrx = 0;
            wait (go_rand);
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                s = 8'($urandom);
                c = 8'($urandom);
                if (k == 0) begin
                    s = 8'hFF;
                    c = 8'hFF;
                end
                vi = 1'b1;
                n  = 0;
                @(negedge clk);
                while (!ri && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (!ri) begin
                    failures++;
                    $display("FAIL rnd_accept_timeout chunk=%0d: in_ready=0 required 1", gc);
                end else begin
                    q.push_back({2'b00, s} + {1'b0, c, 1'b0});
                end
                @(posedge clk);
                #1;
                vi = 1'b0;
            end
        end

        initial begin
            wait (go_rand);
            forever begin
                @(posedge clk);
                #1;
                ro = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin
            if (go_rand && vo && ro) begin
                nrx++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_unexpected chunk=%0d: result=0x%0h", gc, res);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("rnd_result_chunk%0d", gc), res, e);
                    chk($sformatf("rnd_gate_en_chunk%0d", gc), ge, 1);
                end
            end
        end

        assign rand_done[gc] = (nrx >= NR);
    end

    task automatic send(input logic [7:0] s, input logic [7:0] c, input logic [9:0] e);
        int n;
        n        = 0;
        sum_in   = s;
        carry_in = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL main_accept_timeout: in_ready=0 required 1");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_apx(input logic [7:0] s, input logic [7:0] c, input logic [9:0] e);
        int n;
        n    = 0;
        a_s  = s;
        a_c  = c;
        a_vi = 1'b1;
        @(negedge clk);
        while (!a_ri && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!a_ri) begin
            failures++;
            $display("FAIL apx_accept_timeout: in_ready=0 required 1");
        end else begin
            apx_q.push_back(e);
        end
        @(posedge clk);
        #1;
        a_vi = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || apx_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(nm, exp_q.size() + apx_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        carry_in  = '0;
        rr_main   = 1'b0;
        a_vi      = 1'b0;
        a_ro      = 1'b1;
        a_s       = '0;
        a_c       = '0;
        go_rand   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 10'h000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_gate_en", gate_en, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_apx(8'h09, 8'h07, 10'h00F);
        send_apx(8'h0F, 8'h0F, 10'h01F);
        drain("apx_drain");

        sum_in   = 8'h09;
        carry_in = 8'h07;
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        exp_q.push_back(10'h017);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_gate_en", gate_en, 1);
        chk("busy_in_ready", in_ready, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("lat_out_valid_low", out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("lat_out_valid_high", out_valid, 1);

        sum_in   = 8'hFF;
        carry_in = 8'hFF;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 10'h017);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);

        send(8'h0F, 8'hF0, 10'h1EF);
        send(8'hFF, 8'h01, 10'h101);
        send(8'hFF, 8'hFF, 10'h2FD);
        drain("dir_drain");

        sum_in   = 8'h55;
        carry_in = 8'h33;
        in_valid = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_gate_en", gate_en, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 10'h000);
        chk("abort_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_valid", out_valid, 0);

        rr_main = 1'b1;
        for (int k = 0; k < 30; k++) begin
            logic [7:0] s, c;
            s = 8'($urandom);
            c = 8'($urandom);
            send(s, c, {2'b00, s} + {1'b0, c, 1'b0});
        end
        drain("rnd_main_drain");
        rr_main = 1'b0;

        go_rand = 1'b1;
        n = 0;
        while (!(&rand_done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("rnd_all_done", rand_done, 9'h1FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
